// File: rtl/multi_timer_core.sv
// multi_timer_core
// Channel 0 is a settable time-of-day watch. Channels 1..N_CH-1 are
// stopwatches with lap-hold. Every channel advances from one shared 10 ms
// tick. The selected channel drives a registered display bus and takes
// the button pulses.
module multi_timer_core #(
    parameter int N_CH      = 4,
    parameter int TICK_DIV  = 1_000_000,
    parameter int INIT_HOUR = 12,
    parameter int CH_W      = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH_W-1:0] sel,
    input  logic            btn_run,
    input  logic            btn_clear,
    input  logic            btn_lap,
    input  logic            btn_sec,
    input  logic            btn_min,
    input  logic            btn_hour,
    output logic [6:0]      o_msec,
    output logic [6:0]      o_sec,
    output logic [6:0]      o_min,
    output logic [6:0]      o_hour,
    output logic            o_running,
    output logic [N_CH-1:0] o_ch_run
);

    // One time value. Each field is 7 bits so that it matches the display bus.
    typedef struct packed {
        logic [6:0] hour;
        logic [6:0] min;
        logic [6:0] sec;
        logic [6:0] msec;
    } time_t;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_LAP  = 2'b10
    } sw_state_t;

    localparam time_t TIME_ZERO = {7'd0, 7'd0, 7'd0, 7'd0};
    localparam int    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Increment modulo (max_v + 1). A field that is somehow out of range
    // returns to 0 instead of running past its limit.
    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max_v);
        logic [6:0] r;
        if (v >= max_v) begin
            r = 7'd0;
        end else begin
            r = v + 7'd1;
        end
        return r;
    endfunction

    // Advance by one centisecond, with carry from msec through to hour.
    // The hour field wraps 23 -> 0 and has no carry out.
    function automatic time_t time_tick(input time_t t);
        time_t r;
        r      = t;
        r.msec = wrap_inc(t.msec, 7'd99);
        if (t.msec >= 7'd99) begin
            r.sec = wrap_inc(t.sec, 7'd59);
            if (t.sec >= 7'd59) begin
                r.min = wrap_inc(t.min, 7'd59);
                if (t.min >= 7'd59) begin
                    r.hour = wrap_inc(t.hour, 7'd23);
                end else begin
                    r.hour = t.hour;
                end
            end else begin
                r.min = t.min;
            end
        end else begin
            r.sec = t.sec;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == TICK_LAST);

    // Free-running 0..TICK_DIV-1 counter; w_tick marks its last count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= {PW{1'b0}};
        end else if (w_tick) begin
            r_presc <= {PW{1'b0}};
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Watch (channel 0)
    // ------------------------------------------------------------------
    logic  w_sel_watch;
    time_t r_watch;
    time_t w_watch_adv;
    time_t w_watch_nxt;

    assign w_sel_watch = (sel == {CH_W{1'b0}});

    // Watch next value. The tick advance comes first, and then each set
    // button steps its own field of the advanced value, with no carry.
    always_comb begin
        w_watch_adv = r_watch;
        w_watch_nxt = r_watch;
        if (w_tick) begin
            w_watch_adv = time_tick(r_watch);
        end else begin
            w_watch_adv = r_watch;
        end
        w_watch_nxt.msec = w_watch_adv.msec;
        if (w_sel_watch && btn_sec) begin
            w_watch_nxt.sec = wrap_inc(w_watch_adv.sec, 7'd59);
        end else begin
            w_watch_nxt.sec = w_watch_adv.sec;
        end
        if (w_sel_watch && btn_min) begin
            w_watch_nxt.min = wrap_inc(w_watch_adv.min, 7'd59);
        end else begin
            w_watch_nxt.min = w_watch_adv.min;
        end
        if (w_sel_watch && btn_hour) begin
            w_watch_nxt.hour = wrap_inc(w_watch_adv.hour, 7'd23);
        end else begin
            w_watch_nxt.hour = w_watch_adv.hour;
        end
    end

    // Watch register. Reset loads INIT_HOUR:00:00.00
    always_ff @(posedge clk) begin
        if (reset) begin
            r_watch.hour <= 7'(INIT_HOUR);
            r_watch.min  <= 7'd0;
            r_watch.sec  <= 7'd0;
            r_watch.msec <= 7'd0;
        end else begin
            r_watch <= w_watch_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Stopwatch channels 1..N_CH-1
    // ------------------------------------------------------------------
    time_t           w_sw_show [1:N_CH-1];
    logic [N_CH-1:0] w_sw_active;

    assign w_sw_active[0] = 1'b0;

    for (genvar i = 1; i < N_CH; i++) begin : g_sw
        sw_state_t r_state;
        sw_state_t w_state_nxt;
        time_t     r_cnt;
        time_t     w_cnt_nxt;
        time_t     r_lap;
        time_t     w_lap_nxt;
        logic      w_hit;

        assign w_hit = (sel == CH_W'(i));

        // Stopwatch FSM next state and count update. Priority is run > lap > clear.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_lap_nxt   = r_lap;
            if ((r_state != ST_STOP) && w_tick) begin
                w_cnt_nxt = time_tick(r_cnt);
            end else begin
                w_cnt_nxt = r_cnt;
            end
            case (r_state)
                ST_STOP: begin
                    if (w_hit && btn_run) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_hit && btn_clear) begin
                        w_cnt_nxt = TIME_ZERO;
                    end else begin
                        w_state_nxt = ST_STOP;
                    end
                end
                ST_RUN: begin
                    if (w_hit && btn_run) begin
                        w_state_nxt = ST_STOP;
                    end else if (w_hit && btn_lap) begin
                        // Snapshot is the value before this cycle's tick
                        w_lap_nxt   = r_cnt;
                        w_state_nxt = ST_LAP;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_LAP: begin
                    if (w_hit && btn_run) begin
                        w_state_nxt = ST_STOP;
                    end else if (w_hit && btn_lap) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_LAP;
                    end
                end
                default: begin
                    w_state_nxt = ST_STOP;
                end
            endcase
        end

        // Stopwatch state, live count and lap snapshot registers
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_STOP;
                r_cnt   <= TIME_ZERO;
                r_lap   <= TIME_ZERO;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_lap   <= w_lap_nxt;
            end
        end

        assign w_sw_show[i]   = (r_state == ST_LAP) ? r_lap : r_cnt;
        assign w_sw_active[i] = (r_state != ST_STOP);
    end

    // ------------------------------------------------------------------
    // Display selection and output registers
    // ------------------------------------------------------------------
    time_t w_disp;
    logic  w_disp_run;

    // Pick the selected channel's value. An unmapped sel shows zero.
    always_comb begin
        w_disp     = TIME_ZERO;
        w_disp_run = 1'b0;
        if (w_sel_watch) begin
            w_disp = r_watch;
        end else begin
            for (int k = 1; k < N_CH; k++) begin
                w_disp     = (sel == CH_W'(k)) ? w_sw_show[k]   : w_disp;
                w_disp_run = (sel == CH_W'(k)) ? w_sw_active[k] : w_disp_run;
            end
        end
    end

    // Registered display bus and per-channel running flags
    always_ff @(posedge clk) begin
        if (reset) begin
            o_msec    <= 7'd0;
            o_sec     <= 7'd0;
            o_min     <= 7'd0;
            o_hour    <= 7'd0;
            o_running <= 1'b0;
            o_ch_run  <= {N_CH{1'b0}};
        end else begin
            o_msec    <= w_disp.msec;
            o_sec     <= w_disp.sec;
            o_min     <= w_disp.min;
            o_hour    <= w_disp.hour;
            o_running <= w_disp_run;
            o_ch_run  <= w_sw_active;
        end
    end

endmodule

// File: doc/multi_timer_core.md
Name: multi_timer_core

Overview:
- N-channel timekeeping engine: channel 0 is a settable time-of-day watch; channels 1..N_CH-1 are independent stopwatches with lap-hold.
- All channels advance from one shared 10 ms tick prescaler.
- A channel selector routes debounced button pulses to one channel and drives that channel's time onto a registered display bus that feeds the FND controller.
- It replaces the fixed two-source watch/stopwatch pairing.

Parameters:
- N_CH, 4, total channels (2..8); channel 0 is always the watch.
- TICK_DIV, 1_000_000, clk cycles per 10 ms tick (≥2).
- INIT_HOUR, 12, watch hour value loaded on reset (0..23).
- CH_W, 3, width of sel; must satisfy 2^CH_W ≥ N_CH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sel  in  CH_W  selected channel index
- btn_run  in  1  single-cycle pulse, start/stop selected stopwatch
- btn_clear  in  1  single-cycle pulse, zero selected stopwatch
- btn_lap  in  1  single-cycle pulse, lap hold/release
- btn_sec  in  1  single-cycle pulse, watch sec +1
- btn_min  in  1  single-cycle pulse, watch min +1
- btn_hour  in  1  single-cycle pulse, watch hour +1
- o_msec  out  7  displayed centiseconds 0..99
- o_sec  out  7  displayed seconds 0..59
- o_min  out  7  displayed minutes 0..59
- o_hour  out  7  displayed hours 0..23
- o_running  out  1  selected stopwatch is in RUN or LAP
- o_ch_run  out  N_CH  per-channel running flags (bit 0 always 0)

Behaviour:
- Reset (synchronous, active-high; clk is the only clock), sampled on a clk edge. Takes priority over all else, including mid-operation.
  - Prescaler and all stopwatch counts cleared; all stopwatch FSMs go to STOP; lap snapshots cleared.
  - Watch loads INIT_HOUR:00:00.00.
  - Outputs cleared: all o_* = 0, o_running = 0, o_ch_run = 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 for the one cycle where count == TICK_DIV-1. The first tick after reset occurs on cycle TICK_DIV.
- Time arithmetic (watch and running stopwatches):
  - On tick, msec increments; 99 wraps to 0 with carry into sec.
  - sec 59→0 with carry; min 59→0 with carry; hour 23→0 with no carry out.
- Watch (channel 0):
  - Always counts; ignores run/clear/lap.
  - When sel == 0, btn_sec/min/hour each increment their field by 1 mod its range, with no carry into the next field.
  - If a set pulse and a tick land in the same cycle, the set increment applies to the tick-updated field value. Several set buttons in one cycle all apply.
- Stopwatch FSM, one per channel 1..N_CH-1. Buttons act only when sel equals that channel. Priority within a cycle: run > lap > clear.
  - STOP: count frozen. btn_run→RUN. btn_clear zeroes the count. btn_lap ignored.
  - RUN: counts on tick. btn_run→STOP. btn_lap captures the snapshot (the value before this cycle's tick) and →LAP. btn_clear ignored.
  - LAP: keeps counting; displayed value is the snapshot. btn_lap→RUN, display returns to live count. btn_run→STOP, display shows live count. btn_clear ignored.
  - A channel's state and counting are unaffected while it is not selected.
  - o_ch_run[i] = 1 in RUN or LAP.
- Set buttons are ignored when sel ≠ 0. Run/clear/lap are ignored when sel == 0.
- sel ≥ N_CH: all buttons ignored; o_msec/o_sec/o_min/o_hour = 0; o_running = 0.
- Output timing:
  - o_msec..o_hour and o_running are registered, with 1-cycle latency from a sel change or count update.
  - o_ch_run is registered from the FSM state and follows it 1 cycle later.
- No combinational path from any input to any output.

Test Plan:
- TICK_DIV=4, N_CH=4, reset held 2 cycles then released → o_hour=12, others 0. After 400 cycles with sel=0 → display 12:00:01.00.
- sel=1, btn_run pulse, wait 100 ticks, btn_run → o_msec=0, o_sec=1, channel 1 frozen. btn_clear → zeros next cycle. Channels 2/3 remain 0 throughout.
- Channel 2 running, btn_lap at count 00:00:00.37 → display holds 37 while o_ch_run[2]=1. After 20 more ticks, btn_lap → display 57.
- Watch preset 12:59:59.99 via set buttons, then tick → 13:00:00.00. Watch at 23:59:59.99, tick → 00:00:00.00. btn_min at min=59 → min=0, hour unchanged.
- btn_run and btn_clear in the same cycle on a stopped channel 1 showing 5 → enters RUN, count not cleared. btn_sec with sel=1 → watch unchanged.
- reset asserted mid-run on channels 1 and 3 → next cycle all counts 0, o_ch_run=0. sel=5 → outputs 0 and buttons have no effect.
